procyon_mhq_lu_mp: RTL and testbench

Multi-port MHQ lookup stage. Accepts up to OPTN_LU_PORTS LSU miss lookups per cycle and resolves each to an MHQ entry: CAM hit, bypass from the entry currently updating, or a single new allocation shared by all same-line misses. Produces registered per-port tags, retry/replay flags and line-aligned update vectors for the MHQ update stage. Sits between the LSU D-cache tag stage and the MHQ update stage.

---
 rtl/procyon_mhq_lu_mp.sv | 229 ++++++++++++++++++++++
 tb/tb_procyon_mhq_lu_mp.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/procyon_mhq_lu_mp.sv
// Multi-port MHQ lookup stage: resolves LSU misses to one MHQ update per cycle.
// Define PCYN_MHQ_LU_MERGE_EN to merge same-entry lookups from several ports.
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`endif
`ifndef PCYN_OP_FILL
`define PCYN_OP_FILL 5'b10000
`endif
`ifndef PCYN_OP_SB
`define PCYN_OP_SB 5'b01000
`endif
`ifndef PCYN_OP_SH
`define PCYN_OP_SH 5'b01001
`endif
`ifndef PCYN_OP_SW
`define PCYN_OP_SW 5'b01010
`endif

module procyon_mhq_lu_mp #(
  parameter int OPTN_DATA_WIDTH   = 32,
  parameter int OPTN_ADDR_WIDTH   = 32,
  parameter int OPTN_MHQ_DEPTH    = 4,
  parameter int OPTN_DC_LINE_SIZE = 32,
  parameter int OPTN_LU_PORTS     = 2,
  localparam int DS  = OPTN_DATA_WIDTH / 8,
  localparam int D   = OPTN_MHQ_DEPTH,
  localparam int IW  = (D > 1) ? $clog2(D) : 1,
  localparam int LS  = OPTN_DC_LINE_SIZE,
  localparam int OW  = $clog2(LS),
  localparam int AW  = OPTN_ADDR_WIDTH,
  localparam int LA  = AW - OW,
  localparam int DW  = OPTN_DATA_WIDTH,
  localparam int P   = OPTN_LU_PORTS,
  localparam int LDW = LS * 8,
  localparam int OPW = `PCYN_OP_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_mhq_full,
  input  logic [D-1:0]     i_mhq_update_bypass_select,
  input  logic [LA-1:0]    i_mhq_update_bypass_addr,
  input  logic [D-1:0]     i_mhq_alloc_select,
  input  logic [P-1:0]     i_lu_valid,
  input  logic [P-1:0]     i_lu_we,
  input  logic [P-1:0]     i_lu_dc_hit,
  input  logic [P*AW-1:0]  i_lu_addr,
  input  logic [P*OPW-1:0] i_lu_op,
  input  logic [P*DW-1:0]  i_lu_data,
  input  logic [P*D-1:0]   i_lu_hit_select,
  output logic [P*IW-1:0]  o_lu_tag,
  output logic [P-1:0]     o_lu_retry,
  output logic [P-1:0]     o_lu_replay,
  output logic             o_mhq_lookup_allocating,
  output logic [D-1:0]     o_mhq_update_select,
  output logic             o_mhq_update_we,
  output logic [LDW-1:0]   o_mhq_update_wr_data,
  output logic [LS-1:0]    o_mhq_update_byte_select,
  output logic [LA-1:0]    o_mhq_update_addr,
  input  logic             i_ccu_done,
  input  logic             i_mhq_completing,
  input  logic [LA-1:0]    i_mhq_completing_addr,
  input  logic             i_mhq_filling,
  input  logic [LA-1:0]    i_mhq_filling_addr
);

  localparam logic [LS-1:0] MB = LS'(1);
  localparam logic [LS-1:0] MH = LS'({(DS/2){1'b1}});
  localparam logic [LS-1:0] MW = LS'({DS{1'b1}});

  function automatic logic [IW-1:0] enc(input logic [D-1:0] s);
    enc = '0;
    for (int i = 0; i < D; i++)
      if (s[i]) enc = enc | IW'(i);
  endfunction

  logic [LA-1:0]  line [P];
  logic [OW-1:0]  off  [P];
  logic [D-1:0]   sel  [P];
  logic [LS-1:0]  bm   [P];
  logic [LDW-1:0] bd   [P];
  logic [P-1:0]   act, rpl, rty, cb, alp;
  logic [OPW-1:0] op;
  logic           alloc_fnd, lead_fnd, mrg;
  logic [D-1:0]   lead_sel;
  logic [LA-1:0]  lead_line;

  logic [P*IW-1:0] tag_d, tag_q;
  logic [P-1:0]    retry_d, retry_q;
  logic [P-1:0]    replay_d, replay_q;
  logic [D-1:0]    usel_d, usel_q;
  logic            uwe_d, uwe_q;
  logic [LDW-1:0]  udat_d, udat_q;
  logic [LS-1:0]   umsk_d, umsk_q;
  logic [LA-1:0]   uadr_d, uadr_q;

  always_comb begin
    act = '0;
    rpl = '0;
    rty = '0;
    cb = '0;
    alp = '0;
    op = '0;
    mrg = 1'b0;
    alloc_fnd = 1'b0;
    lead_fnd = 1'b0;
    lead_sel = '0;
    lead_line = '0;
    tag_d = '0;
    uwe_d = 1'b0;
    udat_d = '0;
    umsk_d = '0;
    for (int p = 0; p < P; p++) begin
      sel[p] = '0;
      line[p] = i_lu_addr[p*AW+OW +: LA];
      off[p] = i_lu_addr[p*AW +: OW];
      op = i_lu_op[p*OPW +: OPW];
      act[p] = i_lu_valid[p] & ~i_lu_dc_hit[p] &
               (op != `PCYN_OP_FILL);
      rpl[p] = i_lu_valid[p] &
               (((i_ccu_done | i_mhq_completing) &
                 (i_mhq_completing_addr == line[p])) |
                (i_mhq_filling &
                 (i_mhq_filling_addr == line[p])));
      case (op)
        `PCYN_OP_SB: bm[p] = MB << off[p];
        `PCYN_OP_SH: bm[p] = MH << off[p];
        `PCYN_OP_SW: bm[p] = MW << off[p];
        default:     bm[p] = '0;
      endcase
      bd[p] = LDW'(i_lu_data[p*DW +: DW]) << {off[p], 3'b000};
    end

    for (int p = 0; p < P; p++) begin
      mrg = 1'b0;
      if ((|i_mhq_update_bypass_select) &&
          (i_mhq_update_bypass_addr == line[p])) begin
        sel[p] = i_mhq_update_bypass_select;
      end else if (|i_lu_hit_select[p*D +: D]) begin
        sel[p] = i_lu_hit_select[p*D +: D];
      end else begin
        for (int q = 0; q < p; q++) begin
          if (!mrg && act[q] && !rpl[q] &&
              (line[q] == line[p])) begin
            sel[p] = sel[q];
            mrg = 1'b1;
          end
        end
        if (!mrg && act[p] && !rpl[p]) begin
          if (alloc_fnd || i_mhq_full) rty[p] = 1'b1;
          else sel[p] = i_mhq_alloc_select;
          alp[p] = ~alloc_fnd;
          alloc_fnd = 1'b1;
        end
      end
      // A merge onto a retried port leaves nothing to update
      if (act[p] && !rpl[p] && !(|sel[p])) rty[p] = 1'b1;
      tag_d[p*IW +: IW] = enc(sel[p]);
    end

    for (int p = 0; p < P; p++) begin
      if (act[p] && !rpl[p] && !rty[p]) begin
        if (!lead_fnd) begin
          lead_fnd = 1'b1;
          lead_sel = sel[p];
          lead_line = line[p];
          cb[p] = 1'b1;
        end
`ifdef PCYN_MHQ_LU_MERGE_EN
        else if (sel[p] == lead_sel) cb[p] = 1'b1;
`else
        else if (line[p] == lead_line) rpl[p] = 1'b1;
`endif
        else rty[p] = 1'b1;
      end
    end

    // Ascending order lets the youngest store own overlapping bytes
    for (int p = 0; p < P; p++) begin
      if (cb[p]) begin
        uwe_d = uwe_d | i_lu_we[p];
        for (int b = 0; b < LS; b++) begin
          if (bm[p][b]) begin
            umsk_d[b] = 1'b1;
            udat_d[b*8 +: 8] = bd[p][b*8 +: 8];
          end
        end
      end
    end

    retry_d = rty & ~rpl;
    replay_d = rpl;
    usel_d = lead_sel;
    uadr_d = lead_line;
  end

  assign o_mhq_lookup_allocating = (|(cb & alp)) & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q    <= '0;
      retry_q  <= '0;
      replay_q <= '0;
      usel_q   <= '0;
      uwe_q    <= 1'b0;
      udat_q   <= '0;
      umsk_q   <= '0;
      uadr_q   <= '0;
    end else begin
      tag_q    <= tag_d;
      retry_q  <= retry_d;
      replay_q <= replay_d;
      usel_q   <= usel_d;
      uwe_q    <= uwe_d;
      udat_q   <= udat_d;
      umsk_q   <= umsk_d;
      uadr_q   <= uadr_d;
    end
  end

  assign o_lu_tag = tag_q;
  assign o_lu_retry = retry_q;
  assign o_lu_replay = replay_q;
  assign o_mhq_update_select = usel_q;
  assign o_mhq_update_we = uwe_q;
  assign o_mhq_update_wr_data = udat_q;
  assign o_mhq_update_byte_select = umsk_q;
  assign o_mhq_update_addr = uadr_q;

endmodule

// File: tb/tb_procyon_mhq_lu_mp.sv
// Scoreboard bench for procyon_mhq_lu_mp (2 ports, 4 entries, 32B lines).
`timescale 1ns/1ps
`ifndef PCYN_OP_WIDTH
`define PCYN_OP_WIDTH 5
`endif
`ifndef PCYN_OP_FILL
`define PCYN_OP_FILL 5'b10000
`endif
`ifndef PCYN_OP_SB
`define PCYN_OP_SB 5'b01000
`endif
`ifndef PCYN_OP_SH
`define PCYN_OP_SH 5'b01001
`endif
`ifndef PCYN_OP_SW
`define PCYN_OP_SW 5'b01010
`endif

module tb_procyon_mhq_lu_mp;
  localparam logic [4:0] SB = `PCYN_OP_SB;
  localparam logic [4:0] SH = `PCYN_OP_SH;
  localparam logic [4:0] SW = `PCYN_OP_SW;
  localparam logic [4:0] FL = `PCYN_OP_FILL;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         full;
  logic [3:0]   byp_sel;
  logic [26:0]  byp_addr;
  logic [3:0]   alloc_sel;
  logic [1:0]   valid, we, dch;
  logic [63:0]  addr;
  logic [9:0]   op;
  logic [63:0]  data;
  logic [7:0]   hit;
  logic [3:0]   tag;
  logic [1:0]   retry, replay;
  logic         allocating;
  logic [3:0]   usel;
  logic         uwe;
  logic [255:0] udat;
  logic [31:0]  umsk;
  logic [26:0]  uadr;
  logic         ccu_done, comp, filling;
  logic [26:0]  comp_addr, fill_addr;

  procyon_mhq_lu_mp dut (
    .clk(clk),
    .rst(rst),
    .i_mhq_full(full),
    .i_mhq_update_bypass_select(byp_sel),
    .i_mhq_update_bypass_addr(byp_addr),
    .i_mhq_alloc_select(alloc_sel),
    .i_lu_valid(valid),
    .i_lu_we(we),
    .i_lu_dc_hit(dch),
    .i_lu_addr(addr),
    .i_lu_op(op),
    .i_lu_data(data),
    .i_lu_hit_select(hit),
    .o_lu_tag(tag),
    .o_lu_retry(retry),
    .o_lu_replay(replay),
    .o_mhq_lookup_allocating(allocating),
    .o_mhq_update_select(usel),
    .o_mhq_update_we(uwe),
    .o_mhq_update_wr_data(udat),
    .o_mhq_update_byte_select(umsk),
    .o_mhq_update_addr(uadr),
    .i_ccu_done(ccu_done),
    .i_mhq_completing(comp),
    .i_mhq_completing_addr(comp_addr),
    .i_mhq_filling(filling),
    .i_mhq_filling_addr(fill_addr)
  );

  typedef struct {
    int           id;
    logic [3:0]   tag;
    logic [1:0]   rty;
    logic [1:0]   rpl;
    logic [3:0]   sel;
    logic         we;
    logic [31:0]  msk;
    logic [255:0] dat;
    logic [26:0]  adr;
  } exp_t;

  exp_t sbq[$];
  exp_t me;
  int   errs = 0;
  int   chks = 0;
  int   vid = 0;

  task automatic chk(input int id, input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL v%0d %s: got %0h expected %0h",
               id, nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (sbq.size() > 0) begin
      me = sbq.pop_front();
      chk(me.id, "tag", tag, me.tag);
      chk(me.id, "retry", retry, me.rty);
      chk(me.id, "replay", replay, me.rpl);
      chk(me.id, "upd_sel", usel, me.sel);
      chk(me.id, "upd_we", uwe, me.we);
      chk(me.id, "byte_sel", umsk, me.msk);
      chk(me.id, "wr_data", udat, me.dat);
      chk(me.id, "upd_addr", uadr, me.adr);
    end
  end

  task automatic clr();
    full = 1'b0;
    byp_sel = '0;
    byp_addr = '0;
    alloc_sel = 4'b0010;
    valid = '0;
    we = '0;
    dch = '0;
    addr = '0;
    op = '0;
    data = '0;
    hit = '0;
    ccu_done = 1'b0;
    comp = 1'b0;
    filling = 1'b0;
    comp_addr = '0;
    fill_addr = '0;
  endtask

  task automatic setp(input int p, input logic w,
                      input logic [31:0] a, input logic [4:0] o,
                      input logic [31:0] d, input logic [3:0] h);
    valid[p] = 1'b1;
    we[p] = w;
    addr[p*32 +: 32] = a;
    op[p*5 +: 5] = o;
    data[p*32 +: 32] = d;
    hit[p*4 +: 4] = h;
  endtask

  task automatic expo(input logic [3:0] tg, input logic [1:0] rt,
                      input logic [1:0] rp, input logic [3:0] sl,
                      input logic w, input logic [31:0] m,
                      input logic [255:0] d, input logic [26:0] a,
                      input logic al);
    exp_t e;
    e.id = vid;
    e.tag = tg;
    e.rty = rt;
    e.rpl = rp;
    e.sel = sl;
    e.we = w;
    e.msk = m;
    e.dat = d;
    e.adr = a;
    sbq.push_back(e);
    #1 chk(vid, "allocating", allocating, al);
    vid++;
  endtask

  task automatic expz();
    expo('0, '0, '0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      clr();
      setp(0, 1, 32'h1004, SW, 32'hAABBCCDD, 4'b0);
      setp(1, 1, 32'h2000, SW, 32'h01020304, 4'b0);
      expz();
    end

    @(negedge clk);
    rst = 1'b0;
    clr();
    expz();

    @(negedge clk);
    clr();
    setp(0, 1, 32'h1004, SW, 32'hAABBCCDD, 4'b0);
    expo(4'b0001, 2'b00, 2'b00, 4'b0010, 1, 32'h000000F0,
         256'hAABBCCDD_00000000, 27'h80, 1);

    @(negedge clk);
    clr();
    alloc_sel = 4'b0100;
    setp(0, 1, 32'h1000, SW, 32'h12345678, 4'b0);
    setp(1, 1, 32'h1002, SB, 32'h00000011, 4'b0);
`ifdef PCYN_MHQ_LU_MERGE_EN
    expo(4'b1010, 2'b00, 2'b00, 4'b0100, 1, 32'h0000000F,
         256'h12115678, 27'h80, 1);
`else
    expo(4'b1010, 2'b00, 2'b10, 4'b0100, 1, 32'h0000000F,
         256'h12345678, 27'h80, 1);
`endif

    @(negedge clk);
    clr();
    alloc_sel = 4'b0001;
    setp(0, 1, 32'h1000, SW, 32'hCAFEF00D, 4'b0);
    setp(1, 1, 32'h2000, SW, 32'h99999999, 4'b0);
    expo(4'b0000, 2'b10, 2'b00, 4'b0001, 1, 32'h0000000F,
         256'hCAFEF00D, 27'h80, 1);

    @(negedge clk);
    clr();
    full = 1'b1;
    alloc_sel = 4'b0001;
    setp(0, 1, 32'h1000, SW, 32'hCAFEF00D, 4'b0);
    setp(1, 1, 32'h2000, SW, 32'h99999999, 4'b0);
    expo(4'b0000, 2'b11, 2'b00, 4'b0000, 0, '0, '0, '0, 0);

    @(negedge clk);
    clr();
    filling = 1'b1;
    fill_addr = 27'h180;
    setp(0, 1, 32'h1000, SW, 32'h0BADBEEF, 4'b0);
    setp(1, 1, 32'h3008, SW, 32'h77777777, 4'b0);
    expo(4'b0001, 2'b00, 2'b10, 4'b0010, 1, 32'h0000000F,
         256'h0BADBEEF, 27'h80, 1);

    @(negedge clk);
    clr();
    alloc_sel = 4'b1000;
    setp(0, 1, 32'h101E, SW, 32'hDDCCBBAA, 4'b0);
    expo(4'b0011, 2'b00, 2'b00, 4'b1000, 1, 32'hC0000000,
         {16'hBBAA, 240'h0}, 27'h80, 1);

    @(negedge clk);
    clr();
    byp_sel = 4'b0100;
    byp_addr = 27'h80;
    setp(0, 1, 32'h1005, SB, 32'h00000077, 4'b0);
    setp(1, 1, 32'h2000, SB, 32'h00000055, 4'b0001);
    expo(4'b0010, 2'b10, 2'b00, 4'b0100, 1, 32'h00000020,
         256'h77_0000000000, 27'h80, 0);

    @(negedge clk);
    clr();
    setp(0, 0, 32'h1000, SW, 32'h11223344, 4'b0001);
    setp(1, 1, 32'h1002, SH, 32'h0000BEEF, 4'b0001);
`ifdef PCYN_MHQ_LU_MERGE_EN
    expo(4'b0000, 2'b00, 2'b00, 4'b0001, 1, 32'h0000000F,
         256'hBEEF3344, 27'h80, 0);
`else
    expo(4'b0000, 2'b00, 2'b10, 4'b0001, 0, 32'h0000000F,
         256'h11223344, 27'h80, 0);
`endif

    @(negedge clk);
    clr();
    setp(0, 1, 32'h1000, FL, 32'h12121212, 4'b0);
    setp(1, 1, 32'h2000, SW, 32'h55667788, 4'b0);
    expo(4'b0100, 2'b00, 2'b00, 4'b0010, 1, 32'h0000000F,
         256'h55667788, 27'h100, 1);

    @(negedge clk);
    clr();
    rst = 1'b1;
    setp(0, 1, 32'h1000, SW, 32'h12345678, 4'b0);
    expz();

    @(negedge clk);
    clr();
    rst = 1'b0;
    expz();

    for (int i = 0; i < 10 && sbq.size() > 0; i++)
      @(posedge clk);
    #2;
    chks++;
    if (sbq.size() != 0) begin
      errs++;
      $display("FAIL drain: got %0d pending expected 0",
               sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
